// File: rtl/digit_scan_ctrl_pkg.sv
// digit_scan_ctrl_pkg
//   Shared definitions for the four-digit seven-segment scan controller:
//   scan FSM state type, digit count, segment glyph constants
//   ({g,f,e,d,c,b,a}, active-high) and small helpers that pick a digit's
//   nibble out of the 16-bit display word and decide leading-zero blanking.
//   Digit 0 is the most significant nibble (bits 15:12).
package digit_scan_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Nibble shown on digit position idx (0 = most significant).
    function automatic logic [3:0] digit_nibble(input logic [15:0] value,
                                                input logic [1:0]  idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = value[15:12];
            2'd1:    nib = value[11:8];
            2'd2:    nib = value[7:4];
            default: nib = value[3:0];
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every more-significant nibble
    // are zero. The last digit is never a leading zero so 0x0000 shows "0".
    function automatic logic lz_blanked(input logic [15:0] value,
                                        input logic [1:0]  idx);
        logic blank;
        case (idx)
            2'd0:    blank = (value[15:12] == 4'h0);
            2'd1:    blank = (value[15:8]  == 8'h00);
            2'd2:    blank = (value[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_hex_to_7seg.sv
// hex_to_7seg
//   Combinational hex nibble to seven-segment glyph decoder.
//   Ports:
//     hex  in  4  nibble to display
//     seg  out 7  segments {g,f,e,d,c,b,a}, active-high
module hex_to_7seg
    import digit_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl
//   Time-multiplexes a 16-bit hex value over a 4-digit common-cathode
//   seven-segment display. Drives the 2-bit digit select {a,b} for an
//   external 2-to-4 decoder together with the matching segment pattern.
//   The displayed value is double-buffered: loads land in a pending
//   register and move to the shadow (displayed) register only at a frame
//   boundary, so a frame never shows a mix of old and new digits.
//   Ports:
//     clk         in  1   system clock, rising edge
//     rst_n       in  1   synchronous active-low reset
//     en          in  1   scan enable; low freezes scanning, blanks display
//     load        in  1   strobe, captures din into pending register
//     din         in  16  value to show, digit0 = din[15:12]
//     blank_lz    in  1   suppress leading zero digits
//     a, b        out 1   digit select {a,b} = digit index
//     seg         out 7   segments {g,f,e,d,c,b,a}, active-high
//     dig_en      out 1   current digit lit
//     frame_done  out 1   pulse when the index wraps 3 -> 0
//     busy        out 1   a pending value awaits the frame boundary
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CW       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        blank_lz,
    output logic        a,
    output logic        b,
    output logic [6:0]  seg,
    output logic        dig_en,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [CW-1:0] TERM_COUNT = CW'(TICK_DIV - 1);

    scan_state_e  state_q,      state_d;
    logic [CW-1:0] presc_q,     presc_d;
    logic [1:0]   idx_q,        idx_d;
    logic [15:0]  shadow_q,     shadow_d;
    logic [15:0]  pending_q,    pending_d;
    logic         busy_q,       busy_d;
    logic [6:0]   seg_q,        seg_d;
    logic         dig_en_q,     dig_en_d;
    logic         frame_done_q, frame_done_d;

    logic         boundary;
    logic         lit;
    logic [3:0]   cur_nibble;
    logic [6:0]   seg_raw;

    // Next-state: prescaler, digit index and the double buffer.
    always_comb begin
        state_d      = en ? ST_SCAN : ST_IDLE;
        presc_d      = presc_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        boundary     = 1'b0;

        if (en) begin
            if (state_q == ST_SCAN) begin
                if (presc_q == TERM_COUNT) begin
                    presc_d  = '0;
                    idx_d    = idx_q + 2'd1;
                    boundary = (idx_q == 2'd3);
                end else begin
                    presc_d  = presc_q + CW'(1);
                end
            end else begin
                // Leaving IDLE: the current digit gets a full hold period.
                presc_d = '0;
            end
        end

        if (load && boundary) begin
            // Load coinciding with the wrap bypasses the pending stage so
            // the new value is shown from digit0 of the frame starting now.
            shadow_d  = din;
            pending_d = din;
            busy_d    = 1'b0;
        end else begin
            if (boundary && busy_q) begin
                shadow_d = pending_q;
                busy_d   = 1'b0;
            end
            if (load) begin
                pending_d = din;
                busy_d    = 1'b1;
            end
        end

        frame_done_d = boundary;
    end

    // Outputs are computed from next-state values so that seg/dig_en are
    // registered on the same edge as the index and change together.
    assign cur_nibble = digit_nibble(shadow_d, idx_d);

    hex_to_7seg u_hex_to_7seg (
        .hex (cur_nibble),
        .seg (seg_raw)
    );

    always_comb begin
        lit      = (state_d == ST_SCAN) && !(blank_lz && lz_blanked(shadow_d, idx_d));
        seg_d    = lit ? seg_raw : SEG_BLANK;
        dig_en_d = lit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            idx_q        <= 2'd0;
            shadow_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            busy_q       <= 1'b0;
            seg_q        <= SEG_BLANK;
            dig_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign a          = idx_q[1];
    assign b          = idx_q[0];
    assign seg        = seg_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl
//   Drives two scan controllers (hold 4 and hold 2 cycles per digit) from
//   the same stimulus. A behavioural model predicts each cycle's outputs;
//   predictions are queued at stimulus time and a separate monitor pops and
//   compares them against the DUT outputs on the falling edge.
module tb_digit_scan_ctrl;

    typedef struct packed {
        logic       a;
        logic       b;
        logic [6:0] seg;
        logic       den;
        logic       fd;
        logic       busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, en, load, blank_lz;
    logic [15:0] din;

    logic        a4, b4, den4, fd4, busy4;
    logic [6:0]  seg4;
    logic        a2, b2, den2, fd2, busy2;
    logic [6:0]  seg2;

    int checks = 0;
    int failures = 0;
    int printed = 0;
    int frames = 0;

    exp_t q4[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    digit_scan_ctrl #(.TICK_DIV(4), .CW(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
        .blank_lz(blank_lz), .a(a4), .b(b4), .seg(seg4), .dig_en(den4),
        .frame_done(fd4), .busy(busy4)
    );

    digit_scan_ctrl #(.TICK_DIV(2), .CW(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .din(din),
        .blank_lz(blank_lz), .a(a2), .b(b2), .seg(seg2), .dig_en(den2),
        .frame_done(fd2), .busy(busy2)
    );

    // ---------------- reference model ----------------
    bit          m_run  [2];
    int          m_hold [2];
    int          m_idx  [2];
    logic [15:0] m_sh   [2];
    logic [15:0] m_pend [2];
    bit          m_busy [2];

    function automatic int td(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [6:0] glyph(input int n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Advance model k across one clock edge with the given inputs and
    // return the outputs visible after that edge.
    function automatic exp_t model_step(input int k, input logic r, input logic e,
                                        input logic l, input logic [15:0] d,
                                        input logic bz);
        exp_t x;
        bit   bnd;
        bit   lit;
        int   sh_amt;
        x   = '0;
        bnd = 1'b0;
        if (!r) begin
            m_run[k] = 1'b0; m_hold[k] = 0; m_idx[k] = 0;
            m_sh[k] = 16'h0; m_pend[k] = 16'h0; m_busy[k] = 1'b0;
            return x;
        end
        if (e && m_run[k]) begin
            if (m_hold[k] == td(k) - 1) begin
                m_hold[k] = 0;
                bnd = (m_idx[k] == 3);
                m_idx[k] = (m_idx[k] + 1) % 4;
            end else begin
                m_hold[k] = m_hold[k] + 1;
            end
        end else if (e) begin
            m_hold[k] = 0;
        end
        m_run[k] = e;
        if (l && bnd) begin
            m_sh[k] = d;
            m_busy[k] = 1'b0;
        end else begin
            if (bnd && m_busy[k]) begin
                m_sh[k] = m_pend[k];
                m_busy[k] = 1'b0;
            end
            if (l) begin
                m_pend[k] = d;
                m_busy[k] = 1'b1;
            end
        end
        sh_amt = 12 - 4 * m_idx[k];
        lit = m_run[k] && !(bz && m_idx[k] != 3 && (m_sh[k] >> sh_amt) == 16'h0);
        x.a    = (m_idx[k] >= 2);
        x.b    = (m_idx[k] % 2 == 1);
        x.seg  = lit ? glyph(int'((m_sh[k] >> sh_amt) & 16'hF)) : 7'h00;
        x.den  = lit;
        x.fd   = bnd;
        x.busy = m_busy[k];
        return x;
    endfunction

    // ---------------- stimulus ----------------
    logic blz_cur = 1'b1;

    task automatic cyc(input logic r, input logic e, input logic l,
                       input logic [15:0] d, input logic bz);
        exp_t e4, e2;
        rst_n = r; en = e; load = l; din = d; blank_lz = bz;
        e4 = model_step(0, r, e, l, d, bz);
        e2 = model_step(1, r, e, l, d, bz);
        if (l && r)
            $display("load din=%h idx=%0d busy_after=%0b", d, m_idx[0], m_busy[0]);
        @(posedge clk);
        q4.push_back(e4);
        q2.push_back(e2);
        #1;
    endtask

    // Run scanning until the hold-4 model sits at digit want_idx, count
    // want_hold (i.e. the DUT is in that position during the next cycle).
    task automatic wait_pos(input int want_idx, input int want_hold);
        int n;
        n = 0;
        while (!(m_run[0] && m_idx[0] == want_idx && m_hold[0] == want_hold)) begin
            if (n >= 64) begin
                checks++; failures++;
                $display("FAIL wait_pos: position idx=%0d hold=%0d not reached, at idx=%0d hold=%0d",
                         want_idx, want_hold, m_idx[0], m_hold[0]);
                return;
            end
            cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);
            n++;
        end
    endtask

    // ---------------- monitor ----------------
    task automatic compare(input string nm, input exp_t act, input exp_t ex);
        checks++;
        if (act !== ex) begin
            failures++;
            if (printed < 40) begin
                printed++;
                $display("FAIL %s t=%0t: got ab=%b%b seg=%h den=%b fd=%b busy=%b, expected ab=%b%b seg=%h den=%b fd=%b busy=%b",
                         nm, $time, act.a, act.b, act.seg, act.den, act.fd, act.busy,
                         ex.a, ex.b, ex.seg, ex.den, ex.fd, ex.busy);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (q4.size() > 0) begin
            x = q4.pop_front();
            compare("dut4", {a4, b4, seg4, den4, fd4, busy4}, x);
            if (x.fd) begin
                frames++;
                $display("frame %0d done (hold 4): ab=%b%b seg=%h den=%b", frames, a4, b4, seg4, den4);
            end
        end
        if (q2.size() > 0) begin
            x = q2.pop_front();
            compare("dut2", {a2, b2, seg2, den2, fd2, busy2}, x);
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        // Reset for 3 cycles with scanning off.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Free-running scan of 0x0000 with leading-zero blanking.
        blz_cur = 1'b1;
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Mid-frame load; stays pending until the wrap.
        wait_pos(1, 2);
        cyc(1'b1, 1'b1, 1'b1, 16'h12AF, blz_cur);
        for (int i = 0; i < 36; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Load exactly on the wrap cycle: shown from the next digit0.
        wait_pos(3, 3);
        cyc(1'b1, 1'b1, 1'b1, 16'h8000, blz_cur);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Two loads within one frame: last one wins.
        wait_pos(0, 1);
        cyc(1'b1, 1'b1, 1'b1, 16'h1111, blz_cur);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);
        cyc(1'b1, 1'b1, 1'b1, 16'h2222, blz_cur);
        for (int i = 0; i < 36; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Leading-zero blanking of 0x00A0.
        cyc(1'b1, 1'b1, 1'b1, 16'h00A0, blz_cur);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Drop enable mid-hold at digit 2, load while idle, re-enable.
        wait_pos(2, 1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, (i == 3), 16'h5678, blz_cur);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Reset at digit 3 with a value pending: the value is discarded.
        wait_pos(2, 0);
        cyc(1'b1, 1'b1, 1'b1, 16'hBEEF, blz_cur);
        wait_pos(3, 2);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, blz_cur);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 16'h0, blz_cur);

        // Randomized operation.
        begin
            logic e_r;
            e_r = 1'b1;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 19) == 0) e_r = ~e_r;
                if ($urandom_range(0, 39) == 0) blz_cur = ~blz_cur;
                cyc(($urandom_range(0, 299) != 0), e_r,
                    ($urandom_range(0, 7) == 0), 16'($urandom), blz_cur);
            end
        end

        // Let the monitor drain the remaining predictions.
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q4.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain: queue sizes %0d/%0d, expected 0/0", q4.size(), q2.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
